// File: rtl/shiftadder_pkg.sv
// Shared types and helpers for the shift-adder array and its accumulator.
package shiftadder_pkg;

    typedef enum logic {MODE_FULL, MODE_HALVED} mode_e;
    typedef enum logic {ST_IDLE, ST_ACCUM} acc_state_e;

    // Nibble weight between partial-product positions in full recombine.
    localparam int unsigned NibbleShift = 4;
    // Widest value sext() can handle.
    localparam int unsigned SextWidth = 64;

    // Sign-extend the low fromWidth bits of value to SextWidth bits.
    function automatic logic [SextWidth-1:0] sext(input logic [SextWidth-1:0] value,
                                                  input int unsigned fromWidth);
        logic [SextWidth-1:0] shifted;
        shifted = value << (SextWidth - fromWidth);
        return $signed(shifted) >>> (SextWidth - fromWidth);
    endfunction

endpackage

// File: rtl/pp_combine.sv
// Recombines four signed partial products into one product or a 4-lane sum.
module pp_combine
    import shiftadder_pkg::*;
#(
    parameter int unsigned lengthProduct = 8,
    parameter int unsigned lengthAccum   = 32
) (
    input  mode_e                    mode,
    input  logic [lengthProduct-1:0] ppHH,
    input  logic [lengthProduct-1:0] ppHL,
    input  logic [lengthProduct-1:0] ppLH,
    input  logic [lengthProduct-1:0] ppLL,
    output logic [lengthAccum-1:0]   comb
);

    logic [lengthAccum-1:0] hh, hl, lh, ll;

    // Sign-extend each partial product, then weight by position or sum lanes.
    always_comb begin
        hh = lengthAccum'(sext(SextWidth'(ppHH), lengthProduct));
        hl = lengthAccum'(sext(SextWidth'(ppHL), lengthProduct));
        lh = lengthAccum'(sext(SextWidth'(ppLH), lengthProduct));
        ll = lengthAccum'(sext(SextWidth'(ppLL), lengthProduct));
        if (mode == MODE_HALVED) begin
            comb = hh + hl + lh + ll;
        end else begin
            comb = (hh << (2 * NibbleShift)) + ((hl + lh) << NibbleShift) + ll;
        end
    end

endmodule

// File: rtl/config_product_accumulator.sv
// Recombines partial-product beats and accumulates groups of them into results.
module config_product_accumulator
    import shiftadder_pkg::*;
#(
    parameter int unsigned lengthProduct = 8,
    parameter int unsigned lengthAccum   = 32,
    parameter int unsigned countWidth    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     halvedPrecision,
    input  logic [countWidth-1:0]    accumLength,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [lengthProduct-1:0] ppHH,
    input  logic [lengthProduct-1:0] ppHL,
    input  logic [lengthProduct-1:0] ppLH,
    input  logic [lengthProduct-1:0] ppLL,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [lengthAccum-1:0]   out_result
);

    // Input-side group tracking
    logic [countWidth-1:0] inCnt, grpLen, effLen;
    mode_e                 grpMode, effMode;
    logic                  inLast, inAccept;
    logic [lengthAccum-1:0] comb;

    // Stage 1
    logic                   s1Valid, s1Last, s1Advance;
    logic [lengthAccum-1:0] s1Comb;

    // Stage 2
    acc_state_e             state, stateNext;
    logic [lengthAccum-1:0] acc, sum;
    logic [countWidth-1:0]  cnt;

    // Mode and length come from the ports on a group's first beat, else from the held copy.
    always_comb begin
        if (inCnt == '0) begin
            effMode = halvedPrecision ? MODE_HALVED : MODE_FULL;
            effLen  = (accumLength == '0) ? countWidth'(1) : accumLength;
        end else begin
            effMode = grpMode;
            effLen  = grpLen;
        end
        inLast    = ({1'b0, inCnt} + (countWidth + 1)'(1)) == {1'b0, effLen};
        // Only a final beat can stall: it needs the output register free.
        s1Advance = s1Valid && !(s1Last && out_valid && !out_ready);
        in_ready  = !rst && (!s1Valid || s1Advance);
        inAccept  = in_valid && in_ready;
        sum       = ((state == ST_IDLE) ? '0 : acc) + s1Comb;
    end

    pp_combine #(
        .lengthProduct(lengthProduct),
        .lengthAccum  (lengthAccum)
    ) uCombine (
        .mode(effMode),
        .ppHH(ppHH),
        .ppHL(ppHL),
        .ppLH(ppLH),
        .ppLL(ppLL),
        .comb(comb)
    );

    // Hold the group's mode/length and count accepted beats within the group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inCnt   <= '0;
            grpLen  <= countWidth'(1);
            grpMode <= MODE_FULL;
        end else if (inAccept) begin
            grpLen  <= effLen;
            grpMode <= effMode;
            inCnt   <= inLast ? '0 : inCnt + countWidth'(1);
        end
    end

    // Stage 1 register: combined beat plus its end-of-group marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s1Last  <= 1'b0;
            s1Comb  <= '0;
        end else if (inAccept) begin
            s1Valid <= 1'b1;
            s1Last  <= inLast;
            s1Comb  <= comb;
        end else if (s1Advance) begin
            s1Valid <= 1'b0;
        end
    end

    // Group FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Group FSM next state: open on a non-final advance, close on the final one.
    always_comb begin
        stateNext = state;
        if (s1Advance) begin
            stateNext = s1Last ? ST_IDLE : ST_ACCUM;
        end
    end

    // Accumulator, beat counter and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            if (s1Advance) begin
                if (s1Last) begin
                    out_result <= sum;
                    acc        <= '0;
                    cnt        <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + countWidth'(1);
                end
            end
            if (s1Advance && s1Last) begin
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
